// File: rtl/split_stimulus_driver_if.sv
// Handshake bundle between the stimulus driver and a split block:
// packed assignment out on valid/ready, constraint result back as a strobe.
interface split_stimulus_driver_if #(
    parameter int VEC_W = 368
);
    logic [VEC_W-1:0] vec_o;
    logic             vec_valid;
    logic             vec_ready;
    logic             res_valid;
    logic             res_x;

    modport master (
        output vec_o, vec_valid,
        input  vec_ready, res_valid, res_x
    );

    modport slave (
        input  vec_o, vec_valid,
        output vec_ready, res_valid, res_x
    );
endinterface

// File: rtl/split_stimulus_driver.sv
// Pseudo-random assignment generator for a split constraint block; counts issued vectors and satisfying results.
// Latency: start -> first vec_valid in 1+ceil(VEC_W/32) cycles; vec_o held stable while vec_valid && !vec_ready.
module split_stimulus_driver #(
    parameter int          VEC_W     = 368,
    parameter logic [31:0] LFSR_POLY = 32'hB4BC_D35C,
    parameter int          CNT_W     = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          seed,
    input  logic [CNT_W-1:0]     num_samples,
    split_stimulus_driver_if.master bus,
    output logic [CNT_W-1:0]     sample_count,
    output logic [CNT_W-1:0]     sat_count,
    output logic                 busy,
    output logic                 done
);
    localparam int W      = (VEC_W + 31) / 32;
    localparam int K_W    = (W > 1) ? $clog2(W) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(W - 1);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        DRIVE,
        WAIT_RES,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic             w_vec_valid;
    logic             w_busy;
    logic             w_done;
    logic [31:0]      r_lfsr;
    logic [31:0]      w_lfsr_next;
    logic [K_W-1:0]   r_k;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_sample_cnt;
    logic [CNT_W-1:0] r_sat_cnt;

    assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_POLY) : (r_lfsr >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_vec_valid = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                w_done = (r_state == DONE);
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = (num_samples == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                w_busy = 1'b1;
                if (r_k == K_LAST) w_next = DRIVE;
            end
            DRIVE: begin
                w_busy      = 1'b1;
                w_vec_valid = 1'b1;
                if (bus.vec_ready) w_next = WAIT_RES;
            end
            WAIT_RES: begin
                w_busy = 1'b1;
                // r_sample_cnt already includes the vector whose result is arriving now
                if (bus.res_valid) w_next = (r_sample_cnt == r_num) ? DONE : FILL;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr       <= 32'd1;
            r_k          <= '0;
            r_num        <= '0;
            r_sample_cnt <= '0;
            r_sat_cnt    <= '0;
        end else if (w_accept) begin
            r_lfsr       <= (seed == 32'd0) ? 32'd1 : seed;
            r_k          <= '0;
            r_num        <= num_samples;
            r_sample_cnt <= '0;
            r_sat_cnt    <= '0;
        end else begin
            case (r_state)
                FILL: begin
                    r_lfsr <= w_lfsr_next;
                    r_k    <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
                end
                DRIVE: begin
                    if (bus.vec_ready) r_sample_cnt <= r_sample_cnt + 1'b1;
                end
                WAIT_RES: begin
                    if (bus.res_valid && bus.res_x) r_sat_cnt <= r_sat_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // One register per 32-bit word; the top word keeps only the bits below VEC_W.
    for (genvar j = 0; j < W; j++) begin : g_word
        localparam int LO = 32 * j;
        localparam int HI = (32 * j + 31 < VEC_W) ? (32 * j + 31) : (VEC_W - 1);
        logic [HI-LO:0] r_w;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_w <= '0;
            end else if (r_state == FILL && r_k == K_W'(j)) begin
                r_w <= w_lfsr_next[HI-LO:0];
            end
        end

        assign bus.vec_o[HI:LO] = r_w;
    end

    assign bus.vec_valid = w_vec_valid;
    assign sample_count  = r_sample_cnt;
    assign sat_count     = r_sat_cnt;
    assign busy          = w_busy;
    assign done          = w_done;
endmodule
